// File: rtl/meteor_pkg.sv
// Shared types and defaults for the meteor scheduler slice.
package meteor_pkg;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    PLAY    = 2'd1,
    HIT     = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  localparam int DEF_SPAWN_Y   = -128;
  localparam int DEF_FLOOR_Y   = 230;
  localparam int DEF_COL_X0    = 158;
  localparam int DEF_COL_PITCH = 64;

endpackage

// File: rtl/meteor_sched_lfsr8.sv
// 8-bit right-shifting Galois LFSR; seeded non-zero so it never locks up.
module lfsr8
  import meteor_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic [7:0] o_q
);

  logic [7:0] r_q;

  // Shift right, folding the taps back in when the bit shifted out is 1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= LFSR_SEED;
    end else if (i_en) begin
      r_q <= {1'b0, r_q[7:1]} ^ (r_q[0] ? LFSR_TAPS : 8'h00);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/meteor_sched.sv
// Falling-meteor game scheduler: slot positions, spawning, collision, lives, score.
module meteor_sched
  import meteor_pkg::*;
#(
  parameter int unsigned N          = 5,
  parameter int unsigned CORDW      = 16,
  parameter int unsigned NUM_COLS   = 5,
  parameter int          COL_X0     = DEF_COL_X0,
  parameter int          COL_PITCH  = DEF_COL_PITCH,
  parameter int          SPAWN_Y    = DEF_SPAWN_Y,
  parameter int          FLOOR_Y    = DEF_FLOOR_Y,
  parameter int unsigned SPEED_BASE = 2,
  parameter int unsigned SPEED_MAX  = 6,
  parameter int unsigned SPAWN_GAP  = 40,
  parameter int unsigned HIT_FRAMES = 60,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned SCOREW     = 16
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix_n,
  input  logic                 frame,
  input  logic                 de,
  input  logic                 btn_start,
  input  logic                 frog_drawing,
  input  logic [N-1:0]         met_drawing,
  output logic [N*CORDW-1:0]   met_x,
  output logic [N*CORDW-1:0]   met_y,
  output logic [N-1:0]         met_active,
  output logic [1:0]           state,
  output logic [2:0]           lives,
  output logic [SCOREW-1:0]    score,
  output logic                 hit
);

  localparam int unsigned SPW = $clog2(SPAWN_GAP + 1);
  localparam int unsigned HTW = $clog2(HIT_FRAMES + 1);
  localparam int unsigned SLW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNW = $clog2(N + 1);

  typedef logic signed [CORDW-1:0] coord_t;
  localparam coord_t SPAWN_YC = coord_t'(SPAWN_Y);
  localparam coord_t FLOOR_YC = coord_t'(FLOOR_Y);

  game_state_t       r_state;
  logic [2:0]        r_lives;
  logic [SCOREW-1:0] r_score;
  logic              r_hit;
  logic [SPW-1:0]    r_spawn_t;
  logic [HTW-1:0]    r_hit_t;
  logic              r_start_q;
  logic              r_coll;
  logic [N-1:0]      r_active;
  coord_t            r_x [N];
  coord_t            r_y [N];

  logic [7:0]        w_lfsr;
  logic              w_unused_lfsr;
  logic [3:0]        w_col;
  coord_t            w_spawn_x;
  logic [SCOREW:0]   w_speed_raw;
  coord_t            w_speed;
  coord_t            w_y_mv [N];
  logic [N-1:0]      w_ret;
  logic [N-1:0]      w_act_mv;
  logic [N-1:0]      w_spawn_sel;
  logic              w_found;
  logic [SLW-1:0]    w_slot;
  logic [CNW-1:0]    w_nret;
  logic [SCOREW:0]   w_score_sum;
  logic [SCOREW-1:0] w_score_nx;
  logic              w_start_rise;
  logic              w_coll_px;
  logic              w_play_frame;

  lfsr8 u_lfsr (
    .i_clk   (clk_pix),
    .i_rst_n (rst_pix_n),
    .i_en    (1'b1),
    .o_q     (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[7:3];

  assign w_col = ({1'b0, w_lfsr[2:0]} >= 4'(NUM_COLS)) ?
                 ({1'b0, w_lfsr[2:0]} - 4'(NUM_COLS)) : {1'b0, w_lfsr[2:0]};
  assign w_spawn_x = coord_t'(COL_X0 + int'(w_col) * COL_PITCH);

  assign w_speed_raw = (SCOREW+1)'(SPEED_BASE) + (SCOREW+1)'(r_score >> 4);
  assign w_speed     = (w_speed_raw > (SCOREW+1)'(SPEED_MAX)) ?
                       coord_t'(SPEED_MAX) : coord_t'(w_speed_raw);

  assign w_start_rise = btn_start & ~r_start_q;
  assign w_coll_px    = de & frog_drawing & (|met_drawing);
  assign w_play_frame = frame & (r_state == PLAY);

  assign w_score_sum = {1'b0, r_score} + (SCOREW+1)'(w_nret);
  assign w_score_nx  = w_score_sum[SCOREW] ? '1 : w_score_sum[SCOREW-1:0];

  // Per-slot fall/retire, then pick the lowest slot free after retirements for spawning.
  always_comb begin
    w_ret       = '0;
    w_act_mv    = '0;
    w_nret      = '0;
    w_found     = 1'b0;
    w_slot      = '0;
    w_spawn_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_y_mv[i]   = r_y[i] + w_speed;
      w_ret[i]    = r_active[i] & (w_y_mv[i] > FLOOR_YC);
      w_act_mv[i] = r_active[i] & ~w_ret[i];
      w_nret      = w_nret + CNW'(w_ret[i]);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!w_act_mv[i]) begin
        w_found = 1'b1;
        w_slot  = SLW'(i);
      end
    end
    if ((r_spawn_t == '0) && w_found) begin
      w_spawn_sel[w_slot] = 1'b1;
    end
  end

  // Slot positions: only PLAY frames move anything; a collision parks every slot.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_active <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_y[i] <= SPAWN_YC;
        r_x[i] <= coord_t'(COL_X0 + int'(i % NUM_COLS) * COL_PITCH);
      end
    end else if (w_play_frame) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (r_coll) begin
          r_active[i] <= 1'b0;
          r_y[i]      <= SPAWN_YC;
        end else if (w_spawn_sel[i]) begin
          r_active[i] <= 1'b1;
          r_y[i]      <= SPAWN_YC;
          r_x[i]      <= w_spawn_x;
        end else if (r_active[i]) begin
          r_active[i] <= w_act_mv[i];
          r_y[i]      <= w_ret[i] ? SPAWN_YC : w_y_mv[i];
        end
      end
    end
  end

  // Game state, lives, score, timers and the sticky collision flag.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_state   <= ATTRACT;
      r_lives   <= 3'(LIVES);
      r_score   <= '0;
      r_hit     <= 1'b0;
      r_spawn_t <= '0;
      r_hit_t   <= '0;
      r_start_q <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      r_start_q <= btn_start;
      r_hit     <= 1'b0;
      if (frame) begin
        r_coll <= 1'b0;
      end else if (w_coll_px) begin
        r_coll <= 1'b1;
      end
      case (r_state)
        ATTRACT, OVER: begin
          if (w_start_rise) begin
            r_state   <= PLAY;
            r_lives   <= 3'(LIVES);
            r_score   <= '0;
            r_spawn_t <= '0;
            r_coll    <= 1'b0;
          end
        end
        PLAY: begin
          if (frame) begin
            if (r_coll) begin
              r_hit   <= 1'b1;
              r_lives <= r_lives - 3'd1;
              if (r_lives == 3'd1) begin
                r_state <= OVER;
              end else begin
                r_state <= HIT;
                r_hit_t <= HTW'(HIT_FRAMES);
              end
            end else begin
              r_score <= w_score_nx;
              if (r_spawn_t != '0) begin
                r_spawn_t <= r_spawn_t - 1'b1;
              end else if (w_found) begin
                r_spawn_t <= SPW'(SPAWN_GAP - 1);
              end
            end
          end
        end
        HIT: begin
          // Leaving on the decrement that reaches zero gives exactly HIT_FRAMES frozen frames.
          if (frame) begin
            r_hit_t <= r_hit_t - 1'b1;
            if (r_hit_t == HTW'(1)) begin
              r_state   <= PLAY;
              r_spawn_t <= SPW'(SPAWN_GAP - 1);
            end
          end
        end
        default: r_state <= ATTRACT;
      endcase
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_slot_out
    assign met_x[g*CORDW +: CORDW] = r_x[g];
    assign met_y[g*CORDW +: CORDW] = r_y[g];
  end

  assign met_active = r_active;
  assign state      = r_state;
  assign lives      = r_lives;
  assign score      = r_score;
  assign hit        = r_hit;

endmodule

// File: tb/tb_meteor_sched.sv
// Self-checking bench for meteor_sched: behavioural game model plus directed scenarios.
module tb_meteor_sched;

  localparam int N  = 5;
  localparam int CW = 16;
  localparam int ST_ATTRACT = 0;
  localparam int ST_PLAY    = 1;
  localparam int ST_HIT     = 2;
  localparam int ST_OVER    = 3;

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b0;
  logic frame = 1'b0;
  logic de = 1'b0;
  logic btn_start = 1'b0;
  logic frog_drawing = 1'b0;
  logic [N-1:0] met_drawing = '0;
  logic [N*CW-1:0] met_x;
  logic [N*CW-1:0] met_y;
  logic [N-1:0] met_active;
  logic [1:0] state;
  logic [2:0] lives;
  logic [15:0] score;
  logic hit;

  always #5 clk_pix = ~clk_pix;

  meteor_sched #(.N(N), .CORDW(CW)) dut (
    .clk_pix      (clk_pix),
    .rst_pix_n    (rst_pix_n),
    .frame        (frame),
    .de           (de),
    .btn_start    (btn_start),
    .frog_drawing (frog_drawing),
    .met_drawing  (met_drawing),
    .met_x        (met_x),
    .met_y        (met_y),
    .met_active   (met_active),
    .state        (state),
    .lives        (lives),
    .score        (score),
    .hit          (hit)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int gx(input int i);
    logic [CW-1:0] v;
    v = met_x[i*CW +: CW];
    return int'($signed(v));
  endfunction

  function automatic int gy(input int i);
    logic [CW-1:0] v;
    v = met_y[i*CW +: CW];
    return int'($signed(v));
  endfunction

  // ---------------- behavioural model ----------------
  int m_state, m_lives, m_score, m_hit, m_spawn, m_hitt;
  bit m_coll, m_startq, m_valid = 0;
  logic [7:0] m_lfsr;
  bit m_act [N];
  int m_x [N];
  int m_y [N];

  function automatic int m_speed();
    int s;
    s = 2 + m_score / 16;
    return (s > 6) ? 6 : s;
  endfunction

  always @(posedge clk_pix) begin : model
    int spd, nret, slot, col;
    bit rise, coll_old;
    if (!rst_pix_n) begin
      m_state = ST_ATTRACT; m_lives = 3; m_score = 0; m_hit = 0;
      m_spawn = 0; m_hitt = 0; m_coll = 0; m_startq = 0; m_lfsr = 8'h01;
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_y[i] = -128; m_x[i] = 158 + 64 * (i % 5);
      end
      m_valid = 1;
    end else begin
      rise = btn_start && !m_startq;
      coll_old = m_coll;
      if (frame) m_coll = 0;
      else if (de && frog_drawing && (met_drawing != 0)) m_coll = 1;
      m_hit = 0;
      spd = m_speed();
      if (m_state == ST_ATTRACT || m_state == ST_OVER) begin
        if (rise) begin
          m_state = ST_PLAY; m_lives = 3; m_score = 0; m_spawn = 0; m_coll = 0;
        end
      end else if (m_state == ST_PLAY && frame) begin
        if (coll_old) begin
          m_hit = 1;
          m_lives = m_lives - 1;
          for (int i = 0; i < N; i++) begin m_act[i] = 0; m_y[i] = -128; end
          m_state = (m_lives == 0) ? ST_OVER : ST_HIT;
          m_hitt = 60;
        end else begin
          nret = 0;
          for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
              m_y[i] = m_y[i] + spd;
              if (m_y[i] > 230) begin m_act[i] = 0; m_y[i] = -128; nret++; end
            end
          end
          m_score = (m_score + nret > 65535) ? 65535 : m_score + nret;
          if (m_spawn > 0) m_spawn--;
          else begin
            slot = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
            if (slot >= 0) begin
              col = int'(m_lfsr % 8);
              if (col >= 5) col -= 5;
              m_act[slot] = 1; m_x[slot] = 158 + 64 * col; m_y[slot] = -128;
              m_spawn = 39;
            end
          end
        end
      end else if (m_state == ST_HIT && frame) begin
        m_hitt--;
        if (m_hitt == 0) begin m_state = ST_PLAY; m_spawn = 39; end
      end
      m_startq = btn_start;
      m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_entries = 0;
  int prev_state = 0;
  always @(negedge clk_pix) begin
    if (m_valid) begin
      chk("state", int'(state), m_state);
      chk("lives", int'(lives), m_lives);
      chk("score", int'(score), m_score);
      chk("hit", int'(hit), m_hit);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("met_active[%0d]", i), int'(met_active[i]), int'(m_act[i]));
        chk($sformatf("met_x[%0d]", i), gx(i), m_x[i]);
        chk($sformatf("met_y[%0d]", i), gy(i), m_y[i]);
      end
      if (state == 2'd1 && prev_state != 1) n_entries++;
      prev_state = int'(state);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_frame();
    repeat (2) @(negedge clk_pix);
    frame = 1'b1;
    @(negedge clk_pix);
    frame = 1'b0;
  endtask

  task automatic collide(input logic [N-1:0] mask);
    @(negedge clk_pix);
    de = 1'b1; frog_drawing = 1'b1; met_drawing = mask;
    @(negedge clk_pix);
    de = 1'b0; frog_drawing = 1'b0; met_drawing = '0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int xs [N];
    int f, nf, sc, e0;
    int py [N];
    logic [N-1:0] pa;
    int ps;
    bit first_ret, done3, done6, found;
    xs = '{158, 222, 286, 350, 414};

    // 1: reset and idle attract
    repeat (3) @(negedge clk_pix);
    rst_pix_n = 1'b1;
    for (int i = 0; i < 10; i++) do_frame();
    chk("t1_state", int'(state), 0);
    chk("t1_active", int'(met_active), 0);
    chk("t1_lives", int'(lives), 3);
    chk("t1_score", int'(score), 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t1_y%0d", i), gy(i), -128);
      chk($sformatf("t1_x%0d", i), gx(i), xs[i]);
    end

    // 2: start, first spawn, first step, second spawn timing
    @(negedge clk_pix); btn_start = 1'b1;
    @(negedge clk_pix); btn_start = 1'b0;
    f = 0;
    do_frame(); f++;
    chk("t2_active", int'(met_active), 1);
    chk("t2_y0", gy(0), -128);
    chk("t2_x0_col", int'(gx(0) >= 158 && gx(0) <= 414 && ((gx(0) - 158) % 64) == 0), 1);
    do_frame(); f++;
    chk("t2_y0_step", gy(0), -126);
    while (!met_active[1] && f < 100) begin do_frame(); f++; end
    chk("t2_slot1_frame", f, 41);

    // 3: falling, retirement and speed ramp
    first_ret = 0; done3 = 0; done6 = 0;
    while (!done6 && f < 5000) begin
      ps = int'(score); pa = met_active;
      for (int i = 0; i < N; i++) py[i] = gy(i);
      do_frame(); f++;
      if (!first_ret && pa[0] && !met_active[0]) begin
        first_ret = 1;
        chk("t3_retire_frame", f, 181);
        chk("t3_retire_y0", gy(0), -128);
        chk("t3_retire_score", int'(score), 1);
      end
      for (int i = 0; i < N; i++) begin
        if (pa[i] && met_active[i] && gy(i) > py[i]) begin
          if (!done3 && ps == 16) begin chk("t3_step16", gy(i) - py[i], 3); done3 = 1; end
          if (!done6 && ps >= 64) begin chk("t3_step64", gy(i) - py[i], 6); done6 = 1; end
        end
      end
    end
    chk("t3_reached_all", int'(first_ret && done3 && done6), 1);

    // 4: collision, hit pulse, frozen hit period
    collide(5'b00100);
    do_frame();
    chk("t4_hit", int'(hit), 1);
    chk("t4_lives", int'(lives), 2);
    chk("t4_state", int'(state), 2);
    chk("t4_active", int'(met_active), 0);
    @(negedge clk_pix);
    chk("t4_hit_clear", int'(hit), 0);
    nf = 0;
    while (state == 2'd2 && nf < 100) begin
      if (nf == 10) collide(5'b00001);
      do_frame(); nf++;
    end
    chk("t4_hit_frames", nf, 60);
    chk("t4_lives_after", int'(lives), 2);
    chk("t4_y0_parked", gy(0), -128);

    // 5: game over and single restart on held start
    collide(5'b00010);
    do_frame();
    chk("t5_lives1", int'(lives), 1);
    nf = 0;
    while (state == 2'd2 && nf < 100) begin do_frame(); nf++; end
    sc = m_score;
    collide(5'b10000);
    do_frame();
    chk("t5_over_state", int'(state), 3);
    chk("t5_over_lives", int'(lives), 0);
    for (int i = 0; i < 5; i++) do_frame();
    chk("t5_score_frozen", int'(score), sc);
    e0 = n_entries;
    @(negedge clk_pix); btn_start = 1'b1;
    @(negedge clk_pix);
    chk("t5_restart_state", int'(state), 1);
    chk("t5_restart_lives", int'(lives), 3);
    chk("t5_restart_score", int'(score), 0);
    for (int i = 0; i < 100; i++) do_frame();
    chk("t5_one_entry", n_entries - e0, 1);
    btn_start = 1'b0;

    // 6: collision in the same frame as a floor crossing, then reset during HIT
    found = 0; nf = 0;
    while (!found && nf < 400) begin
      for (int i = 0; i < N; i++) if (m_act[i] && m_y[i] + m_speed() > 230) found = 1;
      if (!found) begin do_frame(); nf++; end
    end
    chk("t6_found_crossing", int'(found), 1);
    collide(5'b00001);
    do_frame();
    chk("t6_score", int'(score), 0);
    chk("t6_lives", int'(lives), 2);
    chk("t6_state", int'(state), 2);
    repeat (3) @(negedge clk_pix);
    rst_pix_n = 1'b0;
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    chk("t6_rst_state", int'(state), 0);
    chk("t6_rst_lives", int'(lives), 3);
    chk("t6_rst_score", int'(score), 0);
    chk("t6_rst_active", int'(met_active), 0);
    chk("t6_rst_hit", int'(hit), 0);
    chk("t6_rst_y0", gy(0), -128);
    chk("t6_rst_x1", gx(1), 222);
    repeat (4) @(negedge clk_pix);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
